// File: rtl/disp_scan.sv
// Four-digit seven-segment front-end: double-dabble binary-to-BCD converter feeding a digit scanner.
// Optional leading-zero blanking is enabled by defining DISP_BLANK_LZ_EN.
module disp_scan #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] bin_in,
    input  logic        load,
    output logic        busy,
    output logic        ovf,
    output logic [3:0]  digit,
    output logic [3:0]  an
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t        state_q, state_d;
    logic [13:0]   shift_q, shift_d;
    logic [15:0]   acc_q, acc_d;
    logic [15:0]   acc_adj;
    logic [3:0]    iter_q, iter_d;
    logic          ovfNext_q, ovfNext_d;
    logic [15:0]   disp_q, disp_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] refresh_q;
    logic [1:0]    idx_q;
    logic [3:0]    anRaw;

    // Nibble-local add-3 correction; nibbles never carry into each other.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        iter_d    = iter_q;
        ovfNext_d = ovfNext_q;
        disp_d    = disp_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d   = (bin_in > 14'd9999) ? 14'd9999 : bin_in;
                    ovfNext_d = (bin_in > 14'd9999);
                    acc_d     = 16'd0;
                    iter_d    = 4'd0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                {acc_d, shift_d} = {acc_adj[14:0], shift_q, 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd13) begin
                    disp_d  = {acc_adj[14:0], shift_q[13]};
                    ovf_d   = ovfNext_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            acc_q     <= '0;
            iter_q    <= '0;
            ovfNext_q <= 1'b0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            iter_q    <= iter_d;
            ovfNext_q <= ovfNext_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
        end
    end

    // Scanner runs freely, regardless of conversion activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
            idx_q     <= 2'd0;
        end else if (refresh_q == CW'(REFRESH_DIV - 1)) begin
            refresh_q <= '0;
            idx_q     <= idx_q + 2'd1;
        end else begin
            refresh_q <= refresh_q + CW'(1);
        end
    end

    assign busy  = (state_q == CONV);
    assign ovf   = ovf_q;
    assign digit = disp_q[{idx_q, 2'b00} +: 4];
    assign anRaw = ~(4'b0001 << idx_q);

`ifdef DISP_BLANK_LZ_EN
    logic [1:0] msd;

    // Highest nonzero committed position; position 0 is always lit.
    always_comb begin
        msd = 2'd0;
        if (disp_q[7:4] != 4'd0) msd = 2'd1;
        if (disp_q[11:8] != 4'd0) msd = 2'd2;
        if (disp_q[15:12] != 4'd0) msd = 2'd3;
    end

    assign an = (idx_q > msd) ? 4'b1111 : anRaw;
`else
    assign an = anRaw;
`endif

endmodule

// File: tb/tb_disp_scan.sv
// Randomized and directed bench for disp_scan against a decimal-arithmetic reference model.
// Honors DISP_BLANK_LZ_EN in the expected anode pattern.
module tb_disp_scan;

    localparam int REFRESH_DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [13:0] bin_in;
    logic        load;
    logic        busy;
    logic        ovf;
    logic [3:0]  digit;
    logic [3:0]  an;

    int compareCount = 0;
    int failCount    = 0;
    int edgeCnt      = 0;
    int modelDigits[4];
    bit modelOvf;

    disp_scan #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bin_in (bin_in),
        .load   (load),
        .busy   (busy),
        .ovf    (ovf),
        .digit  (digit),
        .an     (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges seen since reset released; the selected position follows from it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edgeCnt <= 0;
        else        edgeCnt <= edgeCnt + 1;
    end

    task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setModel(input int value);
        int v;
        v = (value > 9999) ? 9999 : value;
        modelOvf = (value > 9999);
        for (int i = 0; i < 4; i++) begin
            modelDigits[i] = v % 10;
            v = v / 10;
        end
    endtask

    task automatic checkOutput(input string tag, input bit checkBusy, input bit expBusy);
        int idx;
        int top;
        logic [3:0] expAn;
        idx   = (edgeCnt / REFRESH_DIV) % 4;
        expAn = ~(4'b0001 << idx);
`ifdef DISP_BLANK_LZ_EN
        top = 0;
        for (int i = 1; i < 4; i++) if (modelDigits[i] != 0) top = i;
        if (idx > top) expAn = 4'b1111;
`else
        top = 3;
`endif
        if (checkBusy) compare($sformatf("%s/busy", tag), 16'(busy), 16'(expBusy));
        compare($sformatf("%s/ovf", tag), 16'(ovf), 16'(modelOvf));
        compare($sformatf("%s/digit%0d", tag, idx), 16'(digit), 16'(modelDigits[idx]));
        compare($sformatf("%s/an%0d(top%0d)", tag, idx, top), 16'(an), 16'(expAn));
    endtask

    task automatic scanCheck(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            checkOutput(tag, 1'b1, 1'b0);
        end
    endtask

    // Loads a value; optionally pulses an ignored load or asserts reset at a given busy cycle.
    task automatic applyStimulus(input int value, input int ignoreCycle, input int ignoreValue,
                                 input int resetCycle);
        int n;
        bit aborted;
        n = 0;
        aborted = 1'b0;
        bin_in = 14'(value);
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        bin_in = 14'($urandom);
        while (busy === 1'b1 && n < 40 && !aborted) begin
            n++;
            checkOutput($sformatf("hold%0d", value), 1'b0, 1'b0);
            if (n == resetCycle) begin
                rst_n = 1'b0;
                #1;
                setModel(0);
                checkOutput("midReset", 1'b1, 1'b0);
                @(negedge clk);
                checkOutput("inReset", 1'b1, 1'b0);
                rst_n = 1'b1;
                aborted = 1'b1;
            end else begin
                load = (n == ignoreCycle);
                if (n == ignoreCycle) bin_in = 14'(ignoreValue);
                @(negedge clk);
            end
        end
        load = 1'b0;
        if (aborted) begin
            scanCheck("postReset", 20);
        end else begin
            compare($sformatf("busyLen%0d", value), 16'(n), 16'd14);
            setModel(value);
            scanCheck($sformatf("show%0d", value), 16);
        end
    endtask

    initial begin
        int v;
        rst_n  = 1'b0;
        load   = 1'b0;
        bin_in = '0;
        setModel(0);
        #1;
        checkOutput("resetAsync", 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("resetHeld", 1'b1, 1'b0);
        rst_n = 1'b1;
        scanCheck("idleScan", 16);

        applyStimulus(1234, -1, 0, -1);
        applyStimulus(16383, -1, 0, -1);
        applyStimulus(5, -1, 0, -1);
        applyStimulus(42, 5, 7777, -1);
        applyStimulus(7, -1, 0, -1);
        applyStimulus(0, -1, 0, -1);
        applyStimulus(9999, -1, 0, -1);
        applyStimulus(10000, -1, 0, -1);
        applyStimulus(90, -1, 0, -1);
        applyStimulus(9999, -1, 0, 7);

        for (int k = 0; k < 10; k++) begin
            v = (k % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
            applyStimulus(v, (k % 3 == 0) ? 1 + int'($urandom_range(0, 12)) : -1,
                          int'($urandom_range(0, 16383)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
